sram_two_master_arbiter: RTL and testbench
==========================================

Name: sram_two_master_arbiter

Overview:
- Shares the single-port 32-bit on-chip SRAM (13-bit word address, 5000 words, byte enables) between two Avalon-MM masters: CPU data master (m0) and DMA master (m1).
- Round-robin grant, one transfer per cycle.
- Sequences the SRAM's 1-cycle read latency (registered address, unregistered q) into per-master readdatavalid.
- Suppresses out-of-range accesses.

Parameters:
- ADDR_W, 13, SRAM word-address width.
- DEPTH, 5000, number of implemented words; addresses >= DEPTH are out of range.
- OOR_READ_VALUE, 32'h0000_0000, readdata returned for an out-of-range read.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_address  in  ADDR_W  word address
- m0_byteenable  in  4  byte lanes
- m0_read  in  1  read request
- m0_write  in  1  write request
- m0_writedata  in  32  write data
- m0_waitrequest  out  1  high = request not accepted this cycle
- m0_readdata  out  32  read data
- m0_readdatavalid  out  1  readdata qualifier
- m1_*  (same set and widths as m0_*)
- ram_address  out  ADDR_W  to SRAM address
- ram_byteenable  out  4  to SRAM byteenable
- ram_chipselect  out  1  to SRAM chipselect
- ram_write  out  1  to SRAM write
- ram_writedata  out  32  to SRAM writedata
- ram_clken  out  1  to SRAM clken; tied 1
- ram_readdata  in  32  from SRAM readdata
- oor_error  out  1  sticky; set on any out-of-range access

Behaviour:
- Request: mX_req = mX_read | mX_write. Read and write asserted together by one master is illegal and treated as a write.
- Priority pointer `prio` (register, reset 0):
  - Only one requester: that requester is granted.
  - Both requesting: master `prio` is granted.
  - After any grant, `prio` <= the non-granted index. Strict alternation under contention.
- Grant is combinational in the request cycle:
  - mX_waitrequest = mX_req & ~grantX.
  - mX_waitrequest = 1 while reset is asserted.
  - An idle master sees waitrequest = 0.
  - A master held off keeps its request and signals stable. The arbiter does not latch the losing request.
- SRAM drive (combinational from the granted master):
  - ram_address, ram_byteenable, ram_writedata are muxed from the granted master.
  - With no grant, they are muxed from m0. This is don't-care; chipselect is low.
  - ram_chipselect = grant_any & in_range.
  - ram_write = granted write & in_range.
  - in_range = (granted address < DEPTH).
- Read tracking:
  - Registers `rd_pend`, `rd_tag`, `rd_oor` capture an accepted read. Reset values: 0, 0, 0.
  - Next cycle: m[rd_tag]_readdatavalid = 1 for exactly one cycle.
  - m[rd_tag]_readdata = rd_oor ? OOR_READ_VALUE : ram_readdata.
  - Read latency is fixed at 1 cycle after acceptance.
  - Back-to-back reads every cycle are supported. Each read's data returns in the following cycle, independent of the new grant.
- readdata outputs:
  - mX_readdata is 0 when mX_readdatavalid is low.
  - mX_readdatavalid reset value 0.
- Writes: complete in the acceptance cycle; no response.
- Out-of-range access:
  - Still accepted (waitrequest low).
  - A write is dropped; the SRAM is not touched.
  - A read returns OOR_READ_VALUE with normal latency.
  - oor_error <= 1. It clears only on reset.
- Reset mid-operation:
  - All registers clear immediately, asynchronously.
  - A pending readdatavalid is discarded.
  - prio returns to 0.
- Simultaneous events:
  - A granted read in cycle N and the return of the read from cycle N-1 coexist. Separate signals; no stall.
  - A write to address A in cycle N followed by a read of A in cycle N+1 returns the new data.
- No combinational path from readdata to waitrequest.

Test Plan:
- Single master: m0 write 0x12345678 to addr 0x0010 (byteenable 0xF), then read 0x0010 → m0_waitrequest 0 both cycles; readdatavalid 1 cycle after read with 0x12345678; m1 signals idle.
- Contention: m0 and m1 both read continuously from reset → grants alternate m0,m1,m0,m1; each master's waitrequest high every other cycle; each readdatavalid pulses the cycle after its grant with the correct tagged data.
- Byte lanes: write 0xFFFFFFFF to 0x0020, then write 0x000000AB with byteenable 0x1 → read returns 0xFFFFFFAB.
- Out of range:
  - m1 write 0xCAFEF00D to addr 5000 → ram_chipselect 0; oor_error 1.
  - m1 read addr 5000 → readdata 0x00000000 with readdatavalid.
  - Read addr 4999 → normal data.
- Reset mid-read: assert reset in the cycle after an accepted m0 read → m0_readdatavalid stays 0; both waitrequests 1 during reset; after release prio=0, so the first simultaneous request is granted to m0.
- Write-then-read hazard: m0 writes 0x55AA55AA to 0x0100 in cycle N, m1 reads 0x0100 in cycle N+1 → m1 gets 0x55AA55AA in cycle N+2.

Source files
------------

// File: rtl/sram_two_master_arbiter.sv
// Round-robin arbiter sharing one single-port 32-bit on-chip SRAM between
// a CPU data master (m0) and a DMA master (m1), both Avalon-MM. One transfer
// is granted per cycle. The SRAM's one-cycle read latency is turned into a
// tagged per-master readdatavalid. Accesses beyond DEPTH are accepted but
// never reach the SRAM.
module sram_two_master_arbiter #(
  parameter int          ADDR_W         = 13,
  parameter int          DEPTH          = 5000,
  parameter logic [31:0] OOR_READ_VALUE = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  output logic              ram_clken,
  input  logic [31:0]       ram_readdata,

  output logic              oor_error
);

  // Depth widened to 32 bits so the range check never truncates.
  localparam logic [31:0] DepthU = DEPTH;

  logic              req0, req1;
  logic              grant0, grant1, grantAny;
  logic [ADDR_W-1:0] selAddress;
  logic              selWrite;
  logic              inRange;
  logic [31:0]       rdData;

  logic prio_q, prio_d;
  logic rdPend_q, rdPend_d;
  logic rdTag_q, rdTag_d;
  logic rdOor_q, rdOor_d;
  logic oorError_q, oorError_d;

  // Grant decision and SRAM-side mux, all in the request cycle.
  always_comb begin
    req0       = m0_read | m0_write;
    req1       = m1_read | m1_write;
    grant0     = req0 & (~req1 | ~prio_q);
    grant1     = req1 & (~req0 | prio_q);
    grantAny   = grant0 | grant1;
    selAddress = grant1 ? m1_address : m0_address;
    selWrite   = grant1 ? m1_write : m0_write;
    inRange    = ({{(32-ADDR_W){1'b0}}, selAddress} < DepthU);
  end

  // Next-state: priority flips to the loser, accepted reads are remembered
  // for one cycle, and any out-of-range access latches the sticky error.
  always_comb begin
    prio_d     = prio_q;
    rdPend_d   = 1'b0;
    rdTag_d    = 1'b0;
    rdOor_d    = 1'b0;
    oorError_d = oorError_q;
    if (grant0) begin
      prio_d = 1'b1;
    end else if (grant1) begin
      prio_d = 1'b0;
    end
    if (grantAny) begin
      rdPend_d = ~selWrite;
      rdTag_d  = grant1;
      rdOor_d  = ~inRange;
      if (!inRange) begin
        oorError_d = 1'b1;
      end
    end
  end

  // State registers; everything clears at once on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q     <= 1'b0;
      rdPend_q   <= 1'b0;
      rdTag_q    <= 1'b0;
      rdOor_q    <= 1'b0;
      oorError_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      rdPend_q   <= rdPend_d;
      rdTag_q    <= rdTag_d;
      rdOor_q    <= rdOor_d;
      oorError_q <= oorError_d;
    end
  end

  assign m0_waitrequest = reset | (req0 & ~grant0);
  assign m1_waitrequest = reset | (req1 & ~grant1);

  assign ram_address    = selAddress;
  assign ram_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  assign ram_writedata  = grant1 ? m1_writedata : m0_writedata;
  assign ram_chipselect = grantAny & inRange;
  assign ram_write      = grantAny & selWrite & inRange;
  assign ram_clken      = 1'b1;

  assign rdData           = rdOor_q ? OOR_READ_VALUE : ram_readdata;
  assign m0_readdatavalid = rdPend_q & ~rdTag_q;
  assign m1_readdatavalid = rdPend_q & rdTag_q;
  assign m0_readdata      = m0_readdatavalid ? rdData : 32'h0;
  assign m1_readdata      = m1_readdatavalid ? rdData : 32'h0;

  assign oor_error = oorError_q;

endmodule

// File: tb/tb_sram_two_master_arbiter.sv
// Directed testbench for sram_two_master_arbiter with a behavioural
// single-port SRAM (registered address, unregistered q) hung off the ram_*
// port. Inputs change 1 ns after a rising edge; outputs are sampled on the
// falling edge.
module tb_sram_two_master_arbiter;

  logic        clk = 1'b0;
  logic        reset;

  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;

  logic [12:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata, ram_readdata;
  logic        oor_error;

  logic [31:0] mem [0:8191];
  logic [12:0] memAddrReg;
  logic        bdWe;
  logic [12:0] bdAddr;
  logic [31:0] bdData;

  int testsRun = 0;
  int testsFailed = 0;

  sram_two_master_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata), .oor_error(oor_error)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM plus a backdoor write port for preloading contents.
  always @(posedge clk) begin
    if (bdWe) begin
      mem[bdAddr] <= bdData;
    end
    if (ram_clken && ram_chipselect) begin
      memAddrReg <= ram_address;
      if (ram_write) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
        end
      end
    end
  end

  assign ram_readdata = mem[memAddrReg];

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleAll();
    m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;
  endtask

  task automatic backdoorWrite(input logic [12:0] a, input logic [31:0] d);
    bdWe = 1'b1; bdAddr = a; bdData = d;
    nextCycle();
    bdWe = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    nextCycle();
  endtask

  task automatic test_reset();
    idleAll();
    m0_read = 1'b1;
    m1_write = 1'b1;
    @(negedge clk);
    testsRun++;
    if (m0_waitrequest !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL reset_m0_wait: got %b expected 1", m0_waitrequest);
    end
    testsRun++;
    if (m1_waitrequest !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL reset_m1_wait: got %b expected 1", m1_waitrequest);
    end
    testsRun++;
    if ({m0_readdatavalid, m1_readdatavalid, oor_error} !== 3'b000) begin
      testsFailed++; $display("[TB] FAIL reset_flags: got %b expected 000", {m0_readdatavalid, m1_readdatavalid, oor_error});
    end
    reset = 1'b0;
    idleAll();
    nextCycle();
    @(negedge clk);
    testsRun++;
    if ({m0_waitrequest, m1_waitrequest, ram_chipselect, ram_clken} !== 4'b0001) begin
      testsFailed++; $display("[TB] FAIL idle_outputs: got %b expected 0001", {m0_waitrequest, m1_waitrequest, ram_chipselect, ram_clken});
    end
    nextCycle();
  endtask

  task automatic test_single_master();
    idleAll();
    m0_write = 1'b1; m0_address = 13'h0010; m0_writedata = 32'h12345678; m0_byteenable = 4'hF;
    @(negedge clk);
    testsRun++;
    if ({m0_waitrequest, m1_waitrequest, ram_chipselect, ram_write} !== 4'b0011) begin
      testsFailed++; $display("[TB] FAIL single_wr: got %b expected 0011", {m0_waitrequest, m1_waitrequest, ram_chipselect, ram_write});
    end
    nextCycle();
    idleAll();
    m0_read = 1'b1; m0_address = 13'h0010;
    @(negedge clk);
    testsRun++;
    if ({m0_waitrequest, ram_chipselect, ram_write, m0_readdatavalid} !== 4'b0100) begin
      testsFailed++; $display("[TB] FAIL single_rd_req: got %b expected 0100", {m0_waitrequest, ram_chipselect, ram_write, m0_readdatavalid});
    end
    nextCycle();
    idleAll();
    @(negedge clk);
    testsRun++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h12345678) begin
      testsFailed++; $display("[TB] FAIL single_rd_data: got valid=%b data=%h expected valid=1 data=12345678", m0_readdatavalid, m0_readdata);
    end
    testsRun++;
    if (m1_readdatavalid !== 1'b0 || m1_readdata !== 32'h0) begin
      testsFailed++; $display("[TB] FAIL single_m1_idle: got valid=%b data=%h expected valid=0 data=00000000", m1_readdatavalid, m1_readdata);
    end
    nextCycle();
    @(negedge clk);
    testsRun++;
    if (m0_readdatavalid !== 1'b0 || m0_readdata !== 32'h0) begin
      testsFailed++; $display("[TB] FAIL single_valid_once: got valid=%b data=%h expected valid=0 data=00000000", m0_readdatavalid, m0_readdata);
    end
    nextCycle();
  endtask

  task automatic test_contention();
    logic expWait0, expWait1, expValid0, expValid1;
    idleAll();
    backdoorWrite(13'h0030, 32'hA0A0_0030);
    backdoorWrite(13'h0031, 32'hB1B1_0031);
    doReset();
    m0_read = 1'b1; m0_address = 13'h0030;
    m1_read = 1'b1; m1_address = 13'h0031;
    for (int k = 0; k < 6; k++) begin
      expWait0  = (k % 2) == 1;
      expWait1  = (k % 2) == 0;
      expValid0 = (k % 2) == 1;
      expValid1 = (k >= 2) && ((k % 2) == 0);
      @(negedge clk);
      testsRun++;
      if (m0_waitrequest !== expWait0 || m1_waitrequest !== expWait1) begin
        testsFailed++; $display("[TB] FAIL contend_wait[%0d]: got %b%b expected %b%b", k, m0_waitrequest, m1_waitrequest, expWait0, expWait1);
      end
      testsRun++;
      if (m0_readdatavalid !== expValid0 || m0_readdata !== (expValid0 ? 32'hA0A0_0030 : 32'h0)) begin
        testsFailed++; $display("[TB] FAIL contend_m0_rd[%0d]: got valid=%b data=%h expected valid=%b", k, m0_readdatavalid, m0_readdata, expValid0);
      end
      testsRun++;
      if (m1_readdatavalid !== expValid1 || m1_readdata !== (expValid1 ? 32'hB1B1_0031 : 32'h0)) begin
        testsFailed++; $display("[TB] FAIL contend_m1_rd[%0d]: got valid=%b data=%h expected valid=%b", k, m1_readdatavalid, m1_readdata, expValid1);
      end
      nextCycle();
    end
    idleAll();
    nextCycle();
  endtask

  task automatic test_byte_lanes();
    idleAll();
    m0_write = 1'b1; m0_address = 13'h0020; m0_writedata = 32'hFFFF_FFFF; m0_byteenable = 4'hF;
    nextCycle();
    m0_writedata = 32'h0000_00AB; m0_byteenable = 4'h1;
    nextCycle();
    idleAll();
    m0_read = 1'b1; m0_address = 13'h0020;
    nextCycle();
    idleAll();
    @(negedge clk);
    testsRun++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hFFFF_FFAB) begin
      testsFailed++; $display("[TB] FAIL byte_lanes: got valid=%b data=%h expected valid=1 data=ffffffab", m0_readdatavalid, m0_readdata);
    end
    nextCycle();
  endtask

  task automatic test_out_of_range();
    idleAll();
    backdoorWrite(13'd5000, 32'hDEAD_BEEF);
    m1_write = 1'b1; m1_address = 13'd5000; m1_writedata = 32'hCAFE_F00D;
    @(negedge clk);
    testsRun++;
    if ({m1_waitrequest, ram_chipselect, ram_write, oor_error} !== 4'b0000) begin
      testsFailed++; $display("[TB] FAIL oor_wr: got %b expected 0000", {m1_waitrequest, ram_chipselect, ram_write, oor_error});
    end
    nextCycle();
    idleAll();
    @(negedge clk);
    testsRun++;
    if (oor_error !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL oor_sticky_set: got %b expected 1", oor_error);
    end
    testsRun++;
    if (mem[13'd5000] !== 32'hDEAD_BEEF) begin
      testsFailed++; $display("[TB] FAIL oor_wr_dropped: got %h expected deadbeef", mem[13'd5000]);
    end
    m1_read = 1'b1; m1_address = 13'd5000;
    nextCycle();
    idleAll();
    @(negedge clk);
    testsRun++;
    if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h0) begin
      testsFailed++; $display("[TB] FAIL oor_rd: got valid=%b data=%h expected valid=1 data=00000000", m1_readdatavalid, m1_readdata);
    end
    nextCycle();
    m1_write = 1'b1; m1_address = 13'd4999; m1_writedata = 32'h1357_9BDF;
    nextCycle();
    idleAll();
    m1_read = 1'b1; m1_address = 13'd4999;
    nextCycle();
    idleAll();
    @(negedge clk);
    testsRun++;
    if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h1357_9BDF) begin
      testsFailed++; $display("[TB] FAIL last_word_rd: got valid=%b data=%h expected valid=1 data=13579bdf", m1_readdatavalid, m1_readdata);
    end
    testsRun++;
    if (oor_error !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL oor_sticky_hold: got %b expected 1", oor_error);
    end
    nextCycle();
  endtask

  task automatic test_reset_mid_read();
    idleAll();
    m0_read = 1'b1; m0_address = 13'h0010;
    nextCycle();
    reset = 1'b1;
    m1_read = 1'b1; m1_address = 13'h0020;
    @(negedge clk);
    testsRun++;
    if (m0_readdatavalid !== 1'b0 || m0_readdata !== 32'h0) begin
      testsFailed++; $display("[TB] FAIL rst_discard: got valid=%b data=%h expected valid=0 data=00000000", m0_readdatavalid, m0_readdata);
    end
    testsRun++;
    if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin
      testsFailed++; $display("[TB] FAIL rst_wait: got %b expected 11", {m0_waitrequest, m1_waitrequest});
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    testsRun++;
    if ({m0_waitrequest, m1_waitrequest, m0_readdatavalid, oor_error} !== 4'b0100) begin
      testsFailed++; $display("[TB] FAIL rst_prio: got %b expected 0100", {m0_waitrequest, m1_waitrequest, m0_readdatavalid, oor_error});
    end
    nextCycle();
    idleAll();
    @(negedge clk);
    testsRun++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h12345678) begin
      testsFailed++; $display("[TB] FAIL rst_first_rd: got valid=%b data=%h expected valid=1 data=12345678", m0_readdatavalid, m0_readdata);
    end
    nextCycle();
  endtask

  task automatic test_back_to_back();
    idleAll();
    m0_write = 1'b1; m0_address = 13'h0100; m0_writedata = 32'h55AA_55AA;
    nextCycle();
    idleAll();
    m1_read = 1'b1; m1_address = 13'h0100;
    @(negedge clk);
    testsRun++;
    if (m1_waitrequest !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL hazard_wait: got %b expected 0", m1_waitrequest);
    end
    nextCycle();
    idleAll();
    @(negedge clk);
    testsRun++;
    if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h55AA_55AA || m0_readdatavalid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL hazard_rd: got m1 valid=%b data=%h m0 valid=%b expected 1 55aa55aa 0", m1_readdatavalid, m1_readdata, m0_readdatavalid);
    end
    nextCycle();
  endtask

  initial begin
    reset = 1'b1;
    bdWe = 1'b0; bdAddr = '0; bdData = '0;
    memAddrReg = '0;
    idleAll();
    @(posedge clk);
    #1;
    test_reset();
    test_single_master();
    test_contention();
    test_byte_lanes();
    test_out_of_range();
    test_reset_mid_read();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
